// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans the list at line_start into a mask, then flags pixel hits one cycle after pix_x.
// SPRITE_SCHED_SNAPSHOT_EN selects a frame-start shadow copy of the list; otherwise the scan reads list_ram live.
module sprite_line_sched #(
  parameter int NUM_ENTRIES = 4,
  parameter int SPRITE_SIZE = 16,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_ENTRIES*24-1:0] list_ram,
  input  logic [2:0]                list_count,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic [9:0]                line_y,
  input  logic [9:0]                pix_x,
  input  logic                      pix_valid,
  output logic                      pix_hit,
  output logic [6:0]                pix_color,
  output logic                      busy,
  output logic [NUM_ENTRIES-1:0]    line_mask
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int EW    = 24;

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_ENTRIES-1:0]  mask_q, mask_d;
  logic [10:0]             xs_q [NUM_ENTRIES];
  logic [10:0]             xs_d [NUM_ENTRIES];
  logic [6:0]              col_q [NUM_ENTRIES];
  logic [6:0]              col_d [NUM_ENTRIES];
  logic                    hit_q, hit_d;
  logic [6:0]              color_q, color_d;

  logic [NUM_ENTRIES*EW-1:0] src_list;
  logic [2:0]                src_cnt;
  logic [2:0]                cnt_clamped;

  assign cnt_clamped = (32'(list_count) > NUM_ENTRIES) ? 3'(NUM_ENTRIES) : list_count;

`ifdef SPRITE_SCHED_SNAPSHOT_EN
  logic [NUM_ENTRIES*EW-1:0] shadow_list_q, shadow_list_d;
  logic [2:0]                shadow_cnt_q, shadow_cnt_d;

  always_comb begin
    shadow_list_d = shadow_list_q;
    shadow_cnt_d  = shadow_cnt_q;
    if (frame_start) begin
      shadow_list_d = list_ram;
      shadow_cnt_d  = cnt_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_list_q <= '0;
      shadow_cnt_q  <= '0;
    end else begin
      shadow_list_q <= shadow_list_d;
      shadow_cnt_q  <= shadow_cnt_d;
    end
  end

  assign src_list = shadow_list_q;
  assign src_cnt  = shadow_cnt_q;
`else
  assign src_list = list_ram;
  assign src_cnt  = cnt_clamped;
`endif

  // Entry under test this scan cycle
  logic [EW-1:0] cur;
  logic [10:0]   cur_ys, cur_xs, ly_ext;
  logic          cur_hit;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (idx_q == IDX_W'(i)) cur = src_list[i*EW +: EW];
    end
    cur_ys  = 11'(cur[23:16]) << SCALE_SHIFT;
    cur_xs  = 11'(cur[15:8]) << SCALE_SHIFT;
    ly_ext  = 11'(line_y);
    cur_hit = (32'(idx_q) < 32'(src_cnt)) && cur[7] &&
              (ly_ext >= cur_ys) && (ly_ext < cur_ys + 11'(SPRITE_SIZE));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    xs_d    = xs_q;
    col_d   = col_q;
    if (frame_start) begin
      mask_d  = '0;
      idx_d   = '0;
      state_d = line_start ? SCAN : IDLE;
    end else if (line_start) begin
      mask_d  = '0;
      idx_d   = '0;
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      mask_d[idx_q] = cur_hit;
      if (cur_hit) begin
        xs_d[idx_q]  = cur_xs;
        col_d[idx_q] = cur[6:0];
      end
      if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
        idx_d   = '0;
        state_d = READY;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Walk from the top index down so the lowest index is the last writer
  logic [10:0] px_ext;
  logic        win_hit;
  logic [6:0]  win_color;

  always_comb begin
    px_ext    = 11'(pix_x);
    win_hit   = 1'b0;
    win_color = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (mask_q[i] && (px_ext >= xs_q[i]) && (px_ext < xs_q[i] + 11'(SPRITE_SIZE))) begin
        win_hit   = 1'b1;
        win_color = col_q[i];
      end
    end
    hit_d   = (state_q == READY) && pix_valid && win_hit;
    color_d = hit_d ? win_color : 7'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      hit_q   <= 1'b0;
      color_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        xs_q[i]  <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      hit_q   <= hit_d;
      color_q <= color_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        xs_q[i]  <= xs_d[i];
        col_q[i] <= col_d[i];
      end
    end
  end

  assign pix_hit   = hit_q;
  assign pix_color = color_q;
  assign busy      = (state_q == SCAN);
  assign line_mask = mask_q;

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed bench for sprite_line_sched: vector table for scan/pixel results plus corner sequences.
module tb_sprite_line_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] list_ram;
  logic [2:0]  list_count;
  logic        frame_start;
  logic        line_start;
  logic [9:0]  line_y;
  logic [9:0]  pix_x;
  logic        pix_valid;
  logic        pix_hit;
  logic [6:0]  pix_color;
  logic        busy;
  logic [3:0]  line_mask;

  int checks   = 0;
  int failures = 0;

  always #20 clk = ~clk;

  sprite_line_sched #(.NUM_ENTRIES(4), .SPRITE_SIZE(16), .SCALE_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .list_ram(list_ram), .list_count(list_count),
    .frame_start(frame_start), .line_start(line_start), .line_y(line_y),
    .pix_x(pix_x), .pix_valid(pix_valid), .pix_hit(pix_hit), .pix_color(pix_color),
    .busy(busy), .line_mask(line_mask)
  );

  typedef struct {
    logic [95:0] ram;
    logic [2:0]  cnt;
    logic [9:0]  ly;
    logic [9:0]  px;
    logic [3:0]  m;
    logic        h;
    logic [6:0]  c;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ent(input logic [7:0] y, input logic [7:0] x, input logic [7:0] cb);
    return {y, x, cb};
  endfunction

  function automatic logic [95:0] lst(input logic [23:0] e0, input logic [23:0] e1,
                                      input logic [23:0] e2, input logic [23:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic add(input logic [95:0] r, input logic [2:0] cnt, input logic [9:0] ly,
                     input logic [9:0] px, input logic [3:0] m, input logic h, input logic [6:0] c);
    vec_t t;
    t.ram = r; t.cnt = cnt; t.ly = ly; t.px = px; t.m = m; t.h = h; t.c = c;
    vecs.push_back(t);
  endtask

  // line_start pulse, then busy must be high for exactly NUM_ENTRIES cycles
  task automatic do_scan(input string tag);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " busy_on"}, busy, 1);
      tick();
    end
    chk({tag, " busy_off"}, busy, 0);
  endtask

  task automatic pixel(input logic [9:0] x);
    pix_valid = 1'b1;
    pix_x     = x;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  logic [23:0] a, b0, b2, c1;

  initial begin
    a  = ent(8'd10, 8'd20, 8'h85);
    b0 = ent(8'd10, 8'd20, 8'h81);
    b2 = ent(8'd10, 8'd20, 8'h83);
    c1 = ent(8'd10, 8'd24, 8'h82);
    add(lst(a, 0, 0, 0), 3'd1, 10'd25, 10'd40, 4'b0001, 1'b1, 7'h05);
    add(lst(a, 0, 0, 0), 3'd1, 10'd25, 10'd56, 4'b0001, 1'b0, 7'h00);
    add(lst(a, 0, 0, 0), 3'd1, 10'd25, 10'd39, 4'b0001, 1'b0, 7'h00);
    add(lst(a, 0, 0, 0), 3'd1, 10'd19, 10'd40, 4'b0000, 1'b0, 7'h00);
    add(lst(a, 0, 0, 0), 3'd1, 10'd35, 10'd55, 4'b0001, 1'b1, 7'h05);
    add(lst(a, 0, 0, 0), 3'd1, 10'd36, 10'd40, 4'b0000, 1'b0, 7'h00);
    add(lst(b0, 0, b2, 0), 3'd3, 10'd20, 10'd45, 4'b0101, 1'b1, 7'h01);
    add(lst(b0, 0, b2, 0), 3'd2, 10'd20, 10'd45, 4'b0001, 1'b1, 7'h01);
    add(lst(ent(8'd10, 8'd20, 8'h01), 0, b2, 0), 3'd3, 10'd20, 10'd45, 4'b0100, 1'b1, 7'h03);
    add(lst(b0, c1, 0, 0), 3'd2, 10'd20, 10'd50, 4'b0011, 1'b1, 7'h01);
    add(lst(b0, c1, 0, 0), 3'd2, 10'd20, 10'd57, 4'b0011, 1'b1, 7'h02);
    add(lst(b0, ent(8'd10, 8'd20, 8'h02), 0, ent(8'd10, 8'd30, 8'h87)), 3'd7, 10'd20, 10'd60,
        4'b1001, 1'b1, 7'h07);
    add(lst(a, 0, 0, 0), 3'd0, 10'd25, 10'd40, 4'b0000, 1'b0, 7'h00);
    add(lst(ent(8'd235, 8'd20, 8'h85), 0, 0, 0), 3'd1, 10'd479, 10'd40, 4'b0001, 1'b1, 7'h05);
    add(lst(ent(8'd250, 8'd20, 8'h85), 0, 0, 0), 3'd1, 10'd479, 10'd40, 4'b0000, 1'b0, 7'h00);
    add(lst(ent(8'd10, 8'd255, 8'h86), 0, 0, 0), 3'd1, 10'd25, 10'd520, 4'b0001, 1'b1, 7'h06);

    // Reset with random inputs
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      list_ram    = {$urandom, $urandom, $urandom};
      list_count  = 3'($urandom);
      frame_start = 1'($urandom);
      line_start  = 1'($urandom);
      line_y      = 10'($urandom);
      pix_x       = 10'($urandom);
      pix_valid   = 1'($urandom);
      tick();
    end
    chk("reset pix_hit", pix_hit, 0);
    chk("reset pix_color", pix_color, 0);
    chk("reset busy", busy, 0);
    chk("reset line_mask", line_mask, 0);
    reset = 1'b0; list_ram = '0; list_count = '0; frame_start = 0; line_start = 0;
    line_y = '0; pix_x = '0; pix_valid = 0;
    tick();
    chk("idle busy", busy, 0);
    chk("idle mask", line_mask, 0);

    foreach (vecs[i]) begin
      list_ram   = vecs[i].ram;
      list_count = vecs[i].cnt;
      line_y     = vecs[i].ly;
      frame();
      do_scan($sformatf("vec%0d", i));
      chk($sformatf("vec%0d mask", i), line_mask, vecs[i].m);
      pixel(vecs[i].px);
      chk($sformatf("vec%0d hit", i), pix_hit, vecs[i].h);
      chk($sformatf("vec%0d color", i), pix_color, vecs[i].c);
    end

    // pix_valid low suppresses a covered pixel
    list_ram = lst(a, 0, 0, 0); list_count = 3'd1; line_y = 10'd25;
    frame();
    do_scan("novalid");
    pix_x = 10'd40; pix_valid = 1'b0;
    tick();
    chk("novalid hit", pix_hit, 0);
    chk("novalid color", pix_color, 0);

    // line_start again mid-scan restarts the scan
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    line_start = 1'b1; tick(); line_start = 1'b0;
    chk("restart mask_cleared", line_mask, 0);
    chk("restart busy0", busy, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("restart busy%0d", k + 1), busy, 1);
    end
    tick();
    chk("restart busy_off", busy, 0);
    chk("restart mask", line_mask, 4'b0001);

    // frame_start mid-scan aborts to IDLE
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    chk("abort partial mask", line_mask, 4'b0001);
    frame();
    chk("abort busy", busy, 0);
    chk("abort mask", line_mask, 0);
    pix_valid = 1'b1; pix_x = 10'd40;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort hit%0d", k), pix_hit, 0);
    end
    pix_valid = 1'b0;
    do_scan("after_abort");
    pixel(10'd40);
    chk("after_abort hit", pix_hit, 1);
    chk("after_abort color", pix_color, 7'h05);

    // frame_start and line_start together: scan sees the new list
    list_ram = lst(ent(8'd10, 8'd20, 8'h89), 0, 0, 0);
    frame_start = 1'b1; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    chk("both busy", busy, 1);
    repeat (4) tick();
    chk("both busy_off", busy, 0);
    chk("both mask", line_mask, 4'b0001);
    pixel(10'd40);
    chk("both color", pix_color, 7'h09);

    // Mid-frame list change without frame_start
    list_ram = lst(ent(8'd100, 8'd20, 8'h8A), 0, 0, 0);
    do_scan("midframe");
`ifdef SPRITE_SCHED_SNAPSHOT_EN
    chk("midframe mask", line_mask, 4'b0001);
    pixel(10'd40);
    chk("midframe hit", pix_hit, 1);
    chk("midframe color", pix_color, 7'h09);
`else
    chk("midframe mask", line_mask, 4'b0000);
    pixel(10'd40);
    chk("midframe hit", pix_hit, 0);
    chk("midframe color", pix_color, 7'h00);
`endif
    line_y = 10'd205;
    do_scan("midframe2");
`ifdef SPRITE_SCHED_SNAPSHOT_EN
    chk("midframe2 mask", line_mask, 4'b0000);
`else
    chk("midframe2 mask", line_mask, 4'b0001);
`endif
    frame();
    do_scan("newframe");
    chk("newframe mask", line_mask, 4'b0001);
    pixel(10'd41);
    chk("newframe color", pix_color, 7'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
